// File: rtl/dilithium_pkg.sv
// dilithium_pkg: mode and state encodings plus prefix lengths shared by the stream ingress
package dilithium_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PREFIX  = 2'd1;
    localparam logic [1:0] S_MSG     = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    localparam logic [1:0] MODE_KEYGEN  = 2'd0;
    localparam logic [1:0] MODE_SIGN    = 2'd1;
    localparam logic [1:0] MODE_VERIFY  = 2'd2;
    localparam logic [1:0] MODE_INVALID = 2'd3;

    localparam logic [9:0] P_KEYGEN    = 10'd4;
    localparam logic [9:0] P_SIGN_L2   = 10'd318;
    localparam logic [9:0] P_SIGN_L3   = 10'd502;
    localparam logic [9:0] P_SIGN_L5   = 10'd610;
    localparam logic [9:0] P_VERIFY_L2 = 10'd467;
    localparam logic [9:0] P_VERIFY_L3 = 10'd656;
    localparam logic [9:0] P_VERIFY_L5 = 10'd899;

    function automatic logic lvl_ok(input logic [2:0] lvl);
        return lvl == 3'd2 || lvl == 3'd3 || lvl == 3'd5;
    endfunction

    // only meaningful when lvl_ok() holds; level 5 is the fallback encoding
    function automatic logic [9:0] prefix_len(input logic [1:0] mode, input logic [2:0] lvl);
        logic [9:0] s, v;
        s = lvl == 3'd2 ? P_SIGN_L2 : lvl == 3'd3 ? P_SIGN_L3 : P_SIGN_L5;
        v = lvl == 3'd2 ? P_VERIFY_L2 : lvl == 3'd3 ? P_VERIFY_L3 : P_VERIFY_L5;
        return mode == MODE_KEYGEN ? P_KEYGEN : mode == MODE_SIGN ? s : v;
    endfunction

endpackage

// File: rtl/skid_buffer_64.sv
// skid_buffer_64: two-entry 64-bit skid buffer between the ingress FSM and the core stream
module skid_buffer_64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        take,
    output logic        valid,
    output logic [63:0] data,
    output logic        full_nxt,
    output logic        empty
);
    logic        skid_valid;
    logic [63:0] skid_data;

    assign empty    = !valid && !skid_valid;
    assign full_nxt = skid_valid ? !take : valid && !take && load;

    // output register refills from the skid entry first so word order is preserved
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid      <= 1'b0;
            data       <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (skid_valid) begin
            if (take) begin
                data       <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!valid || take) begin
            valid <= load;
            if (load) data <= load_data;
        end else if (load) begin
            skid_valid <= 1'b1;
            skid_data  <= load_data;
        end
    end
endmodule

// File: rtl/stream_ingress.sv
// stream_ingress: frames host words (prefix + message) into a Dilithium core stream.
// Define STREAM_INGRESS_FRAME_CHECK_EN to enable framing checks and the err flag.
// CNT_W must be wide enough to hold the longest prefix (899).
module stream_ingress
    import dilithium_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [2:0]  sec_lvl,
    input  logic        valid_i,
    output logic        ready_i,
    input  logic [63:0] data_i,
    input  logic        last_i,
    output logic        valid_o,
    input  logic        ready_o,
    output logic [63:0] data_o,
    output logic        busy,
    output logic        err
);
`ifdef STREAM_INGRESS_FRAME_CHECK_EN
    localparam logic FC = 1'b1;
`else
    localparam logic FC = 1'b0;
`endif

    logic [1:0]       state, state_nxt, mode_q;
    logic [2:0]       lvl_q;
    logic [CNT_W-1:0] cnt;
    logic             err_nxt, ready_nxt, hs, go, bad_cfg, at_p, fwd, skid_nxt, buf_empty;

    assign hs      = valid_i && ready_i;
    assign busy    = state != S_IDLE || !buf_empty;
    assign go      = start && !busy;
    assign bad_cfg = mode == MODE_INVALID || !lvl_ok(sec_lvl);
    assign at_p    = 32'(cnt) + 32'd1 == 32'(prefix_len(mode_q, lvl_q));

    // frame sequencing: which words are forwarded and where each handshake leads
    always_comb begin
        state_nxt = state;
        err_nxt   = err;
        fwd       = 1'b0;
        if (go) begin
            state_nxt = bad_cfg ? S_DISCARD : S_PREFIX;
            err_nxt   = FC && bad_cfg;
        end else if (state == S_PREFIX && hs) begin
            if (FC && last_i && !at_p) begin
                state_nxt = S_IDLE;
                err_nxt   = 1'b1;
            end else begin
                fwd = 1'b1;
                if (at_p && mode_q == MODE_KEYGEN) begin
                    state_nxt = FC && !last_i ? S_DISCARD : S_IDLE;
                    err_nxt   = err || (FC && !last_i);
                end else if (at_p) begin
                    state_nxt = FC && last_i ? S_IDLE : S_MSG;
                    err_nxt   = err || (FC && last_i);
                end
            end
        end else if (state == S_MSG && hs) begin
            fwd       = 1'b1;
            state_nxt = last_i ? S_IDLE : S_MSG;
        end else if (state == S_DISCARD && hs && last_i) begin
            state_nxt = S_IDLE;
        end
    end

    // host ready is registered: open in DISCARD, or in PREFIX/MSG while the skid entry stays free
    assign ready_nxt = state_nxt == S_DISCARD ||
                       ((state_nxt == S_PREFIX || state_nxt == S_MSG) && !skid_nxt);

    // state, latched configuration, saturating prefix counter and the ready/err flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            mode_q  <= '0;
            lvl_q   <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            ready_i <= 1'b0;
        end else begin
            state   <= state_nxt;
            err     <= err_nxt;
            ready_i <= ready_nxt;
            if (go) begin
                mode_q <= mode;
                lvl_q  <= sec_lvl;
                cnt    <= '0;
            end else if (state == S_PREFIX && hs && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    skid_buffer_64 u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (fwd),
        .load_data (data_i),
        .take      (ready_o),
        .valid     (valid_o),
        .data      (data_o),
        .full_nxt  (skid_nxt),
        .empty     (buf_empty)
    );
endmodule

// File: tb/tb_stream_ingress.sv
// tb_stream_ingress: randomized self-checking bench for stream_ingress against a frame-level model
module tb_stream_ingress;
`ifdef STREAM_INGRESS_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [1:0]  mode = '0;
    logic [2:0]  sec_lvl = '0;
    logic        valid_i = 1'b0, last_i = 1'b0, ready_o = 1'b0;
    logic [63:0] data_i = '0;
    logic        ready_i, valid_o, busy, err;
    logic [63:0] data_o;

    stream_ingress dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .sec_lvl (sec_lvl),
        .valid_i (valid_i),
        .ready_i (ready_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_o (ready_o),
        .data_o  (data_o),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    logic [63:0] words [1:1024];
    bit          lastv [1:1024];
    logic [63:0] got [$];
    int          lvt [8] = '{2, 3, 5, 2, 3, 5, 1, 6};
    int          nvec = 0, nbad = 0, idx = 0, ro_pat = 0;
    int          cyc = 0, in_hs = 0, first_in = -1, first_out = -1, hold_err = 0;
    bit          clr = 1'b0, tog = 1'b0, stall_pend = 1'b0;
    logic [63:0] stall_data = '0;

    // observe both streams half a cycle away from the active edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            got.delete();
            in_hs     <= 0;
            first_in  <= -1;
            first_out <= -1;
            hold_err  <= 0;
        end else begin
            if (valid_i && ready_i) begin
                in_hs <= in_hs + 1;
                if (first_in < 0) first_in <= cyc;
            end
            if (valid_o && first_out < 0) first_out <= cyc;
            if (valid_o && ready_o) got.push_back(data_o);
            if (stall_pend && rst && (!valid_o || data_o != stall_data)) hold_err <= hold_err + 1;
        end
        stall_pend <= valid_o && !ready_o && rst;
        stall_data <= data_o;
    end

    task automatic chk(input string tag, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tog = ~tog;
        ready_o = ro_pat == 0 ? 1'b1 : ro_pat == 1 ? tog :
                  ro_pat == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    function automatic int plen(input int md, input int lv);
        if (md == 3 || !(lv == 2 || lv == 3 || lv == 5)) return -1;
        if (md == 0) return 4;
        if (md == 1) return lv == 2 ? 318 : lv == 3 ? 502 : 610;
        return lv == 2 ? 467 : lv == 3 ? 656 : 899;
    endfunction

    function automatic int next_last(input int from, input int n);
        for (int j = from; j < n; j++) if (lastv[j]) return j;
        return n;
    endfunction

    // frame outcome from the framing rules: k words consumed, the first nout forwarded
    function automatic void model(input int md, input int lv, input int n,
                                  output int k, output int nout, output bit e);
        int p  = plen(md, lv);
        int l1 = next_last(1, n);
        if (p < 0) begin
            k = l1; nout = 0; e = FC;
        end else if (FC) begin
            if (l1 < p) begin
                k = l1; nout = l1 - 1; e = 1'b1;
            end else if (md == 0) begin
                k = l1; nout = p; e = l1 != p;
            end else if (l1 == p) begin
                k = p; nout = p; e = 1'b1;
            end else begin
                k = l1; nout = l1; e = 1'b0;
            end
        end else if (md == 0) begin
            k = p; nout = p; e = 1'b0;
        end else begin
            k = next_last(p + 1, n); nout = k; e = 1'b0;
        end
    endfunction

    task automatic setup(input int n);
        for (int j = 1; j <= 1024; j++) begin
            words[j] = {$urandom, $urandom};
            lastv[j] = 1'b0;
        end
        lastv[n] = 1'b1;
    endtask

    task automatic do_start(input int md, input int lv);
        int g = 0;
        valid_i = 1'b0;
        while (busy && g < 4000) begin tick(); g++; end
        chk("idle_before_start", int'(busy), 0);
        start = 1'b1; mode = 2'(md); sec_lvl = 3'(lv); clr = 1'b1;
        tick();
        start = 1'b0; clr = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic drive(input int upto, input int spur);
        int g = 0;
        while (idx <= upto && g < 300) begin
            bit acc;
            valid_i = $urandom_range(0, 3) != 0;
            data_i  = words[idx];
            last_i  = lastv[idx];
            start   = idx == spur;
            if (idx == spur) mode = 2'd3;
            @(negedge clk);
            acc = valid_i && ready_i;
            tick();
            start = 1'b0;
            if (acc) begin idx++; g = 0; end else g++;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic finish_frame(input int k, input int nout, input bit e);
        int g = 0, bad = 0;
        chk("words_driven", idx - 1, k);
        valid_i = 1'b1; data_i = '1; last_i = 1'b0;
        while (busy && g < 4000) begin tick(); g++; end
        repeat (3) tick();
        valid_i = 1'b0;
        chk("busy_drained", int'(busy), 0);
        chk("in_handshakes", in_hs, k);
        chk("out_count", got.size(), nout);
        for (int j = 0; j < got.size() && j < nout; j++) if (got[j] !== words[j + 1]) bad++;
        chk("word_order", bad, 0);
        chk("err_flag", int'(err), int'(e));
        chk("hold_while_stalled", hold_err, 0);
        if (nout > 0) chk("latency", first_out - first_in, 1);
    endtask

    task automatic run_frame(input int md, input int lv, input int n, input int spur);
        int k, nout;
        bit e;
        model(md, lv, n, k, nout, e);
        do_start(md, lv);
        idx = 1;
        drive(k, spur);
        finish_frame(k, nout, e);
    endtask

    task automatic reset_test();
        int sz;
        ro_pat = 0; setup(505); do_start(1, 3); idx = 1;
        drive(199, 0);
        ro_pat = 3; tick();
        drive(200, 0);
        rst = 1'b0;
        tick();
        chk("rst_mid_valid_o", int'(valid_o), 0);
        chk("rst_mid_data_o", int'(data_o != 0), 0);
        chk("rst_mid_ready_i", int'(ready_i), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_err", int'(err), 0);
        rst = 1'b1;
        sz = got.size();
        ro_pat = 0;
        repeat (10) tick();
        chk("no_stale_words", got.size(), sz);
        chk("no_stale_valid", int'(valid_o), 0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_ready_i", int'(ready_i), 0);
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_data_o", int'(data_o != 0), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b1;
        tick();
        ro_pat = 0; setup(4);   run_frame(0, 2, 4, 0);
        ro_pat = 2; setup(6);   run_frame(0, 2, 6, 0);
        ro_pat = 1; setup(505); run_frame(1, 3, 505, 0);
        ro_pat = 2; setup(905); lastv[100] = 1'b1; run_frame(2, 5, 905, 0);
        ro_pat = 0; setup(4);   run_frame(0, 3, 4, 0);
        setup(5);               run_frame(3, 2, 5, 0);
        setup(3);               run_frame(1, 4, 3, 0);
        ro_pat = 2; setup(320); lastv[318] = 1'b1; run_frame(1, 2, 320, 0);
        setup(660);             run_frame(2, 3, 660, 10);
        setup(4); lastv[2] = 1'b1; run_frame(0, 5, 4, 0);
        reset_test();
        repeat (6) begin
            int md, lv, p, n;
            md = $urandom_range(0, 3);
            lv = lvt[$urandom_range(0, 7)];
            p  = plen(md, lv);
            n  = (p > 0 ? p : 4) + $urandom_range(1, 12);
            setup(n);
            if ($urandom_range(0, 2) == 0) lastv[$urandom_range(1, n)] = 1'b1;
            if (md == 0 && $urandom_range(0, 1) == 1) lastv[4] = 1'b1;
            ro_pat = $urandom_range(0, 2);
            run_frame(md, lv, n, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
